// File: rtl/seq_divider_32_if.sv
//------------------------------------------------------------------------------
// seq_divider_32_if : start/busy/done handshake and operand/result bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, A, B,
    input  busy, done, Quotient, Remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, A, B,
    output busy, done, Quotient, Remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider_32.sv
//------------------------------------------------------------------------------
// seq_divider_32 : multi-cycle restoring divider (DIVU; DIV when DIV_SIGNED_EN)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_32_if.slave bus
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Partial remainder is always below the divisor, so WIDTH bits hold it;
  // the extra trial bit only exists transiently after the shift.
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_dvs;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_dbz;
  logic               r_zero;
  logic [WIDTH-1:0]   r_q_out;
  logic [WIDTH-1:0]   r_r_out;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_b_zero;
  logic               w_done;
  logic               w_accept;

  assign w_b_zero = (bus.B == '0);
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_shift  = {r_rem, r_quot[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};

`ifdef DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = bus.is_signed & bus.A[WIDTH-1];
  assign w_b_neg = bus.is_signed & bus.B[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag = w_b_neg ? -bus.B : bus.B;
  assign w_q_fix = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix = r_neg_r ? -r_rem  : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_sign;

  assign w_unused_sign = bus.is_signed;
  assign w_a_mag       = bus.A;
  assign w_b_mag       = bus.B;
  assign w_q_fix       = r_quot;
  assign w_r_fix       = r_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Zero divisor detours through FIX so the result load lives in one place,
  // which puts done in the second cycle after the accepting edge.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_next = w_b_zero ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == c_LAST) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quot  <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_dbz   <= 1'b0;
      r_zero  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_busy <= 1'b1;
          r_dbz  <= 1'b0;
          r_zero <= w_b_zero;
          r_rem  <= '0;
          r_cnt  <= '0;
          r_dvs  <= w_b_mag;
          r_quot <= w_b_zero ? bus.A : w_a_mag;
        end
        S_CALC: begin
          r_rem  <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt  <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (r_zero) begin
            r_q_out <= '1;
            r_r_out <= r_quot;
            r_dbz   <= 1'b1;
          end else begin
            r_q_out <= w_q_fix;
            r_r_out <= w_r_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = w_done;
  assign bus.Quotient    = r_q_out;
  assign bus.Remainder   = r_r_out;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_32.sv
//------------------------------------------------------------------------------
// tb_seq_divider_32 : scoreboard bench with directed, hand-computed vectors
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    string       nm;
  } exp_t;

  exp_t sb[$];

  seq_divider_32_if #(.WIDTH(32)) bus ();

  seq_divider_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] q, input logic [31:0] r, input logic z, input string nm);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_quot"}, bus.Quotient, e.q);
        chk({e.nm, "_rem"},  bus.Remainder, e.r);
        chk({e.nm, "_dbz"},  {31'd0, bus.div_by_zero}, {31'd0, e.z});
        chk({e.nm, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic wait_done(input int lat, input string nm);
    int n;
    int nb;
    n  = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) nb++;
    end while (bus.done !== 1'b1 && n < 200);
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_busy_cycles"}, nb, lat - 1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int lat, input string nm);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.is_signed = s; bus.start = 1'b1;
    push(eq, er, ez, nm);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, nm);
  endtask

  initial begin
    int n;
    int ndone;
    int tdone;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
    chk("rst_quot", bus.Quotient, 32'd0);
    chk("rst_rem",  bus.Remainder, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 34, "u_ffff_div16");

    // Abort mid-CALC: reset must clear everything at once, no result produced.
    @(negedge clk);
    bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_quot", bus.Quotient, 32'd0);
    chk("abort_rem",  bus.Remainder, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, "u_100_div7");
    run_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2, "div_zero");
    run_op(32'd3, 32'd7, 1'b0, 32'd0, 32'd3, 1'b0, 34, "u_small_num");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34, "u_equal_max");
    run_op(32'hDEAD_BEEF, 32'd1, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 34, "u_div1");
`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, "s_m7_div2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, "s_overflow");
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, "s_100_divm7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, "s_mode_off");
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, "nosgn_m7_div2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34, "nosgn_overflow");
`endif
    run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 2, "div_zero_sgn");

    // Handshake: extra starts at cycles 5 and 34 are ignored; operands change after E0.
    @(negedge clk);
    bus.A = 32'd1000; bus.B = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
    push(32'd333, 32'd1, 1'b0, "hs_1000_div3");
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.A = 32'd7; bus.B = 32'd2;
    ndone = 0;
    tdone = 0;
    for (n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        tdone = n;
      end
      bus.start = (n == 5 || n == 34);
    end
    chk("hs_done_count", ndone, 1);
    chk("hs_done_cycle", tdone, 34);
    chk("hs_idle_after", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.A = 32'd7; bus.B = 32'd2; bus.start = 1'b1;
    push(32'd3, 32'd1, 1'b0, "hs_new_op");
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(34, "hs_new_op");

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
